pre_decode: RTL and testbench
=============================

# pre_decode

Pre-decode (pD) stage between instruction fetch and decode. It latches the fetch-stage bus and captures the instruction SRAM read data, which is valid only in the cycle after the request. It holds that data across downstream stalls and statically predicts direct LoongArch branches. It drives the predict bus back to fetch and drops its content on any pipeline redirect.

## Interface
- `RESET_PC`, default 32'h1bff_fffc: PC value reported on `pDD_BUS` while the stage is invalid (debug only).
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous reset, active high. One clock; reset is synchronous and active-high.
- `FpD_valid` in 1: fetch bus valid.
- `FpD_BUS` in 43, with fields:
  - [42:11] pc of the requested instruction
  - [10] pc_en, set when the SRAM request was issued
  - [9] ex
  - [8:1] ecode
  - [0] esubcode
- `inst_sram_rdata` in 32: read data for the request issued in the previous cycle.
- `D_allowin` in 1: decode stage can accept.
- `br_taken_D`, `br_taken_E`, `ex_en`, `ertn_flush` in 1 each: redirect events (flush).
- `pD_allowin` out 1: stage can accept from fetch.
- `predict_BUS` out 33: {taken[32], target[31:0]}.
- `pDD_valid` out 1: decode bus valid.
- `pDD_BUS` out 107, with fields:
  - [106:75] pc
  - [74:43] inst
  - [42] pred_taken
  - [41:10] pred_target
  - [9] ex
  - [8:1] ecode
  - [0] esubcode

## Operation
- Derived signals:
  - flush = br_taken_D | br_taken_E | ex_en | ertn_flush.
  - pD_allowin = !pD_valid | D_allowin.
  - accept = FpD_valid & FpD_BUS[10] & pD_allowin.
- Registers: pD_valid, pc, ex, ecode, esubcode, fresh, inst_buf[31:0], redirected.
- Load on accept:
  - pD_valid ← 1.
  - The pc and exception fields are copied from FpD_BUS.
  - fresh ← 1; redirected ← 0.
  - Accept is honoured even in a flush cycle, because fetch has already steered pc_next to the redirect target.
- Otherwise:
  - If flush, or (pD_valid & D_allowin): pD_valid ← 0.
  - fresh ← 0.
- Instruction select: inst = ex ? 32'h0 : (fresh ? inst_sram_rdata : inst_buf).
  - When fresh=1, inst_buf ← inst_sram_rdata.
  - inst_buf is otherwise held, so stalls of any length return the original word.
- Static predictor (ex=0 only):
  - B (inst[31:26]=6'b010100) and BL (6'b010101): taken. target = pc + sext({inst[9:0],inst[25:10],2'b00}), 28-bit value sign-extended to 32 bits.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU (6'b010110..6'b011011): taken iff inst[25]=1 (backward). target = pc + sext({inst[25:10],2'b00}).
  - JIRL and all other opcodes: not taken.
  - All addition is modulo 2^32; wrap-around is silent.
- predict_BUS:
  - taken = pD_valid & !ex & pred_hit & !redirected & !flush.
  - target = the computed target; it is driven regardless of taken.
  - redirected ← 1 when taken & pD_allowin, meaning fetch consumed the redirect. This prevents a second redirect while the branch waits in pD.
  - If pD stalls (pD_allowin=0), taken stays asserted until fetch can take it.
- pDD_valid = pD_valid & !flush.
- pDD_BUS carries pc, inst, pred_hit/target as computed, and the exception fields.

## Timing
- Reset values:
  - pD_valid=0, fresh=0, redirected=0, inst_buf=0, pc=RESET_PC, ex/ecode/esubcode=0.
  - Outputs during reset: pDD_valid=0, predict_BUS=33'h0 (taken=0, target computed from reset regs, ignored), pD_allowin=1.
- Latency: pc to pD is 1 cycle. The instruction is available combinationally in the first pD cycle. The predict redirect reaches fetch pc_next in that same cycle, so no wrong-path fetch is issued.
- Throughput: 1 instruction/cycle with no stalls.
- Reset asserted mid-stall clears all state next edge. No partial instruction survives.
- Simultaneous flush and stall: flush wins; content dropped.
- Simultaneous flush and accept: the new entry is loaded and the old one is dropped.
- Entries with pc_en=0 are never loaded.

## Test plan
- **Streaming:** pc 0x1c000000, 0x1c000004, 0x1c000008 with D_allowin=1 and rdata 0x02800c21 (non-branch) → pDD_valid each cycle one cycle after request, correct pc/inst pairs, predict taken=0.
- **Stall hold:** accept pc 0x1c000010 with rdata 0x12345678, then D_allowin=0 for 3 cycles while rdata changes to 0xdeadbeef → pDD_BUS inst stays 0x12345678 and pD_allowin=0 throughout.
- **B taken:** pc 0x1c000020, inst 0x50000800 (B, offs=+8) → predict_BUS=33'h1_1c000028 for exactly the cycle(s) until pD_allowin=1, then 0 while the entry remains.
- **Backward BEQ:** pc 0x1c000100, inst with inst[25]=1, offs16=16'hfffc → target 0x1c0000f0, taken=1. The same inst with inst[25]=0 → taken=0.
- **Flush:** pD holds a valid entry and br_taken_E=1 with a simultaneous accept of pc 0x1c000200 → pDD_valid=0 and predict taken=0 that cycle; next cycle pD holds 0x1c000200.
- **ADEF:** FpD ex=1, ecode=ADEF, pc 0x1c000002 → pDD_BUS inst=0, ex=1, ecode preserved, predict taken=0.

Source files
------------

// File: rtl/pre_decode.sv
// Pre-decode stage: latches the fetch bus, captures/holds instruction SRAM data,
// and statically predicts direct LoongArch branches back to fetch.
module pre_decode #(
  parameter logic [31:0] RESET_PC = 32'h1bff_fffc
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         FpD_valid,
  input  logic [42:0]  FpD_BUS,
  input  logic [31:0]  inst_sram_rdata,
  input  logic         D_allowin,
  input  logic         br_taken_D,
  input  logic         br_taken_E,
  input  logic         ex_en,
  input  logic         ertn_flush,
  output logic         pD_allowin,
  output logic [32:0]  predict_BUS,
  output logic         pDD_valid,
  output logic [106:0] pDD_BUS
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_ex;
  logic [7:0]  r_ecode;
  logic        r_esubcode;
  logic        r_fresh;
  logic [31:0] r_inst_buf;
  logic        r_redirected;

  logic        w_flush;
  logic        w_accept;
  logic [31:0] w_inst;
  logic [5:0]  w_op;
  logic        w_is_b;
  logic        w_is_cond;
  logic        w_hit;
  logic [31:0] w_target;
  logic        w_taken;

  // B/BL offset: {offs[9:0], offs[25:10]} words, 28-bit byte offset sign-extended
  function automatic logic signed [31:0] offs26_sext(input logic [31:0] inst);
    logic [25:0] offs;
    offs = {inst[9:0], inst[25:10]};
    return {{4{offs[25]}}, offs, 2'b00};
  endfunction

  function automatic logic signed [31:0] offs16_sext(input logic [31:0] inst);
    return {{14{inst[25]}}, inst[25:10], 2'b00};
  endfunction

  assign w_flush    = br_taken_D | br_taken_E | ex_en | ertn_flush;
  assign pD_allowin = !r_valid | D_allowin;
  assign w_accept   = FpD_valid & FpD_BUS[10] & pD_allowin;

  // SRAM data is only valid in the first pD cycle; afterwards use the captured copy
  assign w_inst = r_ex ? 32'h0 : (r_fresh ? inst_sram_rdata : r_inst_buf);

  always_comb begin
    w_op      = w_inst[31:26];
    w_is_b    = (w_op == 6'b010100) || (w_op == 6'b010101);
    w_is_cond = (w_op >= 6'b010110) && (w_op <= 6'b011011);
    w_hit     = !r_ex & (w_is_b | (w_is_cond & w_inst[25]));
    w_target  = 32'h0;
    if (w_is_b)
      w_target = r_pc + offs26_sext(w_inst);
    else if (w_is_cond)
      w_target = r_pc + offs16_sext(w_inst);
  end

  assign w_taken     = r_valid & !r_ex & w_hit & !r_redirected & !w_flush;
  assign predict_BUS = {w_taken, w_target};
  assign pDD_valid   = r_valid & !w_flush;
  assign pDD_BUS     = {r_pc, w_inst, w_hit, w_target, r_ex, r_ecode, r_esubcode};

  // Stage register: fetch -> pD boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_ex         <= 1'b0;
      r_ecode      <= 8'h0;
      r_esubcode   <= 1'b0;
      r_fresh      <= 1'b0;
      r_inst_buf   <= 32'h0;
      r_redirected <= 1'b0;
    end else begin
      if (r_fresh)
        r_inst_buf <= inst_sram_rdata;
      if (w_accept) begin
        r_valid      <= 1'b1;
        r_pc         <= FpD_BUS[42:11];
        r_ex         <= FpD_BUS[9];
        r_ecode      <= FpD_BUS[8:1];
        r_esubcode   <= FpD_BUS[0];
        r_fresh      <= 1'b1;
        r_redirected <= 1'b0;
      end else begin
        if (w_flush || (r_valid && D_allowin))
          r_valid <= 1'b0;
        r_fresh <= 1'b0;
        if (w_taken && pD_allowin)
          r_redirected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pre_decode.sv
// Directed bench for pre_decode: streaming, stall hold, prediction, flush, exceptions, reset.
module tb_pre_decode;

  localparam logic [31:0] RST_PC = 32'h1bff_fffc;

  logic         clk = 1'b0;
  logic         rst;
  logic         FpD_valid;
  logic [42:0]  FpD_BUS;
  logic [31:0]  inst_sram_rdata;
  logic         D_allowin;
  logic         br_taken_D, br_taken_E, ex_en, ertn_flush;
  logic         pD_allowin;
  logic [32:0]  predict_BUS;
  logic         pDD_valid;
  logic [106:0] pDD_BUS;

  int n_chk  = 0;
  int n_fail = 0;

  pre_decode #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .FpD_valid(FpD_valid), .FpD_BUS(FpD_BUS),
    .inst_sram_rdata(inst_sram_rdata), .D_allowin(D_allowin),
    .br_taken_D(br_taken_D), .br_taken_E(br_taken_E), .ex_en(ex_en),
    .ertn_flush(ertn_flush), .pD_allowin(pD_allowin), .predict_BUS(predict_BUS),
    .pDD_valid(pDD_valid), .pDD_BUS(pDD_BUS)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    FpD_valid = 1'b0; FpD_BUS = '0; inst_sram_rdata = '0; D_allowin = 1'b1;
    br_taken_D = 1'b0; br_taken_E = 1'b0; ex_en = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic en, input logic ex, input logic [7:0] ec);
    FpD_valid = 1'b1;
    FpD_BUS   = {pc, en, ex, ec, 1'b0};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); #1;
    check_eq("rst_valid",   pDD_valid,         0);
    check_eq("rst_allowin", pD_allowin,        1);
    check_eq("rst_predict", predict_BUS,       0);
    check_eq("rst_pc",      pDD_BUS[106:75],   RST_PC);
    tick();
    rst = 1'b0;

    // streaming three non-branch instructions
    fetch(32'h1c000000, 1, 0, 0);
    tick();
    fetch(32'h1c000004, 1, 0, 0); inst_sram_rdata = 32'h02800c21; #1;
    check_eq("s0_valid", pDD_valid, 1);
    check_eq("s0_pc",    pDD_BUS[106:75], 32'h1c000000);
    check_eq("s0_inst",  pDD_BUS[74:43],  32'h02800c21);
    check_eq("s0_taken", predict_BUS[32], 0);
    tick();
    fetch(32'h1c000008, 1, 0, 0); #1;
    check_eq("s1_pc",    pDD_BUS[106:75], 32'h1c000004);
    check_eq("s1_valid", pDD_valid, 1);
    tick();
    FpD_valid = 1'b0; #1;
    check_eq("s2_pc",    pDD_BUS[106:75], 32'h1c000008);
    check_eq("s2_inst",  pDD_BUS[74:43],  32'h02800c21);
    tick(); #1;
    check_eq("s3_empty", pDD_valid, 0);

    // stall hold
    fetch(32'h1c000010, 1, 0, 0);
    tick();
    idle(); inst_sram_rdata = 32'h12345678; D_allowin = 1'b0; #1;
    check_eq("st0_inst",    pDD_BUS[74:43], 32'h12345678);
    check_eq("st0_allowin", pD_allowin, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_sram_rdata = 32'hdeadbeef; #1;
      check_eq("st_inst",    pDD_BUS[74:43], 32'h12345678);
      check_eq("st_allowin", pD_allowin, 0);
      check_eq("st_valid",   pDD_valid, 1);
    end
    tick();
    D_allowin = 1'b1; #1;
    check_eq("st_drain_allowin", pD_allowin, 1);
    check_eq("st_drain_inst",    pDD_BUS[74:43], 32'h12345678);
    tick(); #1;
    check_eq("st_gone", pDD_valid, 0);

    // B taken, held while stalled
    fetch(32'h1c000020, 1, 0, 0);
    tick();
    idle(); inst_sram_rdata = 32'h50000800; D_allowin = 1'b0; #1;
    check_eq("b_pred0", predict_BUS, 33'h1_1c000028);
    tick();
    inst_sram_rdata = 32'h0; #1;
    check_eq("b_pred1", predict_BUS, 33'h1_1c000028);
    tick();
    D_allowin = 1'b1; #1;
    check_eq("b_pred2", predict_BUS, 33'h1_1c000028);
    tick(); #1;
    check_eq("b_after", predict_BUS[32], 0);

    // backward BEQ then forward BEQ
    fetch(32'h1c000100, 1, 0, 0);
    tick();
    fetch(32'h1c000104, 1, 0, 0); inst_sram_rdata = 32'h5bfff000; #1;
    check_eq("beq_back",     predict_BUS, 33'h1_1c0000f0);
    check_eq("beq_back_bus", pDD_BUS[42:10], 33'h1_1c0000f0);
    tick();
    FpD_valid = 1'b0; inst_sram_rdata = 32'h59fff000; #1;
    check_eq("beq_fwd", predict_BUS, 33'h0_1c0200f4);
    check_eq("beq_fwd_hit", pDD_BUS[42], 0);
    tick(); #1;

    // flush with simultaneous accept
    fetch(32'h1c000300, 1, 0, 0);
    tick();
    fetch(32'h1c000200, 1, 0, 0); inst_sram_rdata = 32'h50000800; br_taken_E = 1'b1; #1;
    check_eq("fl_valid", pDD_valid, 0);
    check_eq("fl_taken", predict_BUS[32], 0);
    tick();
    idle(); D_allowin = 1'b0; inst_sram_rdata = 32'h02800c21; #1;
    check_eq("fl_new_valid", pDD_valid, 1);
    check_eq("fl_new_pc",    pDD_BUS[106:75], 32'h1c000200);
    // flush during stall drops the entry
    tick();
    ex_en = 1'b1; #1;
    check_eq("fs_valid", pDD_valid, 0);
    tick();
    ex_en = 1'b0; D_allowin = 1'b1; #1;
    check_eq("fs_dropped", pDD_valid, 0);

    // pc_en=0 never loaded
    fetch(32'h1c000400, 0, 0, 0);
    tick();
    idle(); #1;
    check_eq("noen_valid", pDD_valid, 0);

    // ADEF exception entry
    fetch(32'h1c000002, 1, 1, 8'h08);
    tick();
    idle(); inst_sram_rdata = 32'h50000800; #1;
    check_eq("adef_valid", pDD_valid, 1);
    check_eq("adef_inst",  pDD_BUS[74:43], 32'h0);
    check_eq("adef_exc",   pDD_BUS[9:0], 10'h210);
    check_eq("adef_taken", predict_BUS[32], 0);
    check_eq("adef_pc",    pDD_BUS[106:75], 32'h1c000002);
    tick();

    // reset during a stall clears everything
    fetch(32'h1c000500, 1, 0, 0);
    tick();
    idle(); D_allowin = 1'b0; inst_sram_rdata = 32'h50000800; rst = 1'b1;
    tick(); #1;
    check_eq("rs_valid",   pDD_valid, 0);
    check_eq("rs_pc",      pDD_BUS[106:75], RST_PC);
    check_eq("rs_allowin", pD_allowin, 1);
    check_eq("rs_inst",    pDD_BUS[74:43], 32'h0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
